// File: rtl/mem_stage_hs.sv
// MEM stage of the flowCPU MIPS32 pipeline: passes write-back info through and executes
// loads/stores against a req/ack data memory, with lane alignment, extension and misalignment/timeout reporting.
module mem_stage_hs #(
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned REG_ADDR_W  = 5,
   parameter int unsigned ACK_TIMEOUT = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [REG_ADDR_W-1:0] wd_i,
   input  logic                  wreg_i,
   input  logic [31:0]           wdata_i,
   input  logic [3:0]            memop_i,
   input  logic [ADDR_W-1:0]     addr_i,
   input  logic [31:0]           sdata_i,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [ADDR_W-1:0]     mem_addr,
   output logic [3:0]            mem_be,
   output logic [31:0]           mem_wdata,
   input  logic                  mem_ack,
   input  logic [31:0]           mem_rdata,
   output logic                  out_valid,
   output logic [REG_ADDR_W-1:0] wd_o,
   output logic                  wreg_o,
   output logic [31:0]           wdata_o,
   output logic                  stall_req,
   output logic                  misalign_o,
   output logic                  timeout_o
);

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } stateE;

   typedef enum logic [3:0] {
      OP_NONE = 4'd0,
      OP_LB   = 4'd1,
      OP_LBU  = 4'd2,
      OP_LH   = 4'd3,
      OP_LHU  = 4'd4,
      OP_LW   = 4'd5,
      OP_SB   = 4'd6,
      OP_SH   = 4'd7,
      OP_SW   = 4'd8
   } memOpE;

   localparam logic [31:0] TIMEOUT_LAST = (ACK_TIMEOUT == 0) ? 32'd0 : 32'(ACK_TIMEOUT - 1);

   stateE                  state_q, state_d;
   logic [31:0]            cnt_q, cnt_d;
   logic                   memReq_q, memReq_d;
   logic                   memWe_q, memWe_d;
   logic [ADDR_W-1:0]      memAddr_q, memAddr_d;
   logic [3:0]             memBe_q, memBe_d;
   logic [31:0]            memWdata_q, memWdata_d;
   logic                   outValid_q, outValid_d;
   logic [REG_ADDR_W-1:0]  wd_q, wd_d;
   logic                   wreg_q, wreg_d;
   logic [31:0]            wdata_q, wdata_d;
   logic                   misalign_q, misalign_d;
   logic                   timeout_q, timeout_d;
   logic [REG_ADDR_W-1:0]  pendWd_q, pendWd_d;
   logic                   pendWreg_q, pendWreg_d;
   memOpE                  pendOp_q, pendOp_d;
   logic [1:0]             pendLane_q, pendLane_d;

   logic                   isLoad;
   logic                   isStore;
   logic                   misaligned;
   logic [3:0]             reqBe;
   logic [31:0]            reqWdata;
   logic [31:0]            addrExt;
   logic [ADDR_W-1:0]      wordAddr;
   logic [31:0]            laneShifted;
   logic [15:0]            halfSel;
   logic [31:0]            loadData;

   // Misaligned accesses report the faulting address on the 32-bit write-back bus.
   if (ADDR_W >= 32) begin : gAddrTrunc
      assign addrExt = addr_i[31:0];
   end else begin : gAddrZext
      assign addrExt = {{(32 - ADDR_W){1'b0}}, addr_i};
   end

   assign wordAddr  = {addr_i[ADDR_W-1:2], 2'b00};
   assign in_ready  = (state_q == IDLE);
   assign stall_req = (state_q != IDLE);

   // Decode the incoming op into load/store class, alignment fault and byte-lane request fields.
   always_comb begin
      isLoad     = 1'b0;
      isStore    = 1'b0;
      misaligned = 1'b0;
      reqBe      = 4'b1111;
      reqWdata   = sdata_i;
      case (memop_i)
         4'd1, 4'd2: isLoad = 1'b1;
         4'd3, 4'd4: begin
            isLoad     = 1'b1;
            misaligned = addr_i[0];
         end
         4'd5: begin
            isLoad     = 1'b1;
            misaligned = (addr_i[1:0] != 2'b00);
         end
         4'd6: begin
            isStore  = 1'b1;
            reqBe    = 4'b0001 << addr_i[1:0];
            reqWdata = {4{sdata_i[7:0]}};
         end
         4'd7: begin
            isStore    = 1'b1;
            misaligned = addr_i[0];
            reqBe      = addr_i[1] ? 4'b1100 : 4'b0011;
            reqWdata   = {2{sdata_i[15:0]}};
         end
         4'd8: begin
            isStore    = 1'b1;
            misaligned = (addr_i[1:0] != 2'b00);
         end
         default: ;
      endcase
   end

   // Select and extend the addressed byte/halfword of the returned word using the latched lane.
   always_comb begin
      laneShifted = mem_rdata >> {pendLane_q, 3'b000};
      halfSel     = pendLane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      loadData    = mem_rdata;
      case (pendOp_q)
         OP_LB:   loadData = {{24{laneShifted[7]}}, laneShifted[7:0]};
         OP_LBU:  loadData = {24'd0, laneShifted[7:0]};
         OP_LH:   loadData = {{16{halfSel[15]}}, halfSel};
         OP_LHU:  loadData = {16'd0, halfSel};
         default: loadData = mem_rdata;
      endcase
   end

   // Next-state logic: result pulses default low, everything else holds unless an event updates it.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      memReq_d   = memReq_q;
      memWe_d    = memWe_q;
      memAddr_d  = memAddr_q;
      memBe_d    = memBe_q;
      memWdata_d = memWdata_q;
      outValid_d = 1'b0;
      wd_d       = wd_q;
      wreg_d     = wreg_q;
      wdata_d    = wdata_q;
      misalign_d = 1'b0;
      timeout_d  = 1'b0;
      pendWd_d   = pendWd_q;
      pendWreg_d = pendWreg_q;
      pendOp_d   = pendOp_q;
      pendLane_d = pendLane_q;

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               if (misaligned) begin
                  outValid_d = 1'b1;
                  misalign_d = 1'b1;
                  wd_d       = wd_i;
                  wreg_d     = 1'b0;
                  wdata_d    = addrExt;
               end else if (isLoad || isStore) begin
                  memReq_d   = 1'b1;
                  memWe_d    = isStore;
                  memAddr_d  = wordAddr;
                  memBe_d    = reqBe;
                  memWdata_d = reqWdata;
                  pendWd_d   = wd_i;
                  pendWreg_d = wreg_i;
                  pendOp_d   = memOpE'(memop_i);
                  pendLane_d = addr_i[1:0];
                  cnt_d      = 32'd0;
                  state_d    = WAIT;
               end else begin
                  outValid_d = 1'b1;
                  wd_d       = wd_i;
                  wreg_d     = wreg_i;
                  wdata_d    = wdata_i;
               end
            end
         end
         WAIT: begin
            if (mem_ack) begin
               memReq_d   = 1'b0;
               outValid_d = 1'b1;
               wd_d       = pendWd_q;
               wreg_d     = memWe_q ? 1'b0 : pendWreg_q;
               wdata_d    = memWe_q ? 32'd0 : loadData;
               state_d    = IDLE;
            end else if ((ACK_TIMEOUT != 0) && (cnt_q == TIMEOUT_LAST)) begin
               memReq_d   = 1'b0;
               outValid_d = 1'b1;
               timeout_d  = 1'b1;
               wd_d       = pendWd_q;
               wreg_d     = 1'b0;
               wdata_d    = 32'd0;
               state_d    = IDLE;
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers; reset abandons any outstanding request.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= 32'd0;
         memReq_q   <= 1'b0;
         memWe_q    <= 1'b0;
         memAddr_q  <= '0;
         memBe_q    <= 4'd0;
         memWdata_q <= 32'd0;
         outValid_q <= 1'b0;
         wd_q       <= '0;
         wreg_q     <= 1'b0;
         wdata_q    <= 32'd0;
         misalign_q <= 1'b0;
         timeout_q  <= 1'b0;
         pendWd_q   <= '0;
         pendWreg_q <= 1'b0;
         pendOp_q   <= OP_NONE;
         pendLane_q <= 2'd0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         memReq_q   <= memReq_d;
         memWe_q    <= memWe_d;
         memAddr_q  <= memAddr_d;
         memBe_q    <= memBe_d;
         memWdata_q <= memWdata_d;
         outValid_q <= outValid_d;
         wd_q       <= wd_d;
         wreg_q     <= wreg_d;
         wdata_q    <= wdata_d;
         misalign_q <= misalign_d;
         timeout_q  <= timeout_d;
         pendWd_q   <= pendWd_d;
         pendWreg_q <= pendWreg_d;
         pendOp_q   <= pendOp_d;
         pendLane_q <= pendLane_d;
      end
   end

   assign mem_req    = memReq_q;
   assign mem_we     = memWe_q;
   assign mem_addr   = memAddr_q;
   assign mem_be     = memBe_q;
   assign mem_wdata  = memWdata_q;
   assign out_valid  = outValid_q;
   assign wd_o       = wd_q;
   assign wreg_o     = wreg_q;
   assign wdata_o    = wdata_q;
   assign misalign_o = misalign_q;
   assign timeout_o  = timeout_q;

endmodule

// File: tb/tb_mem_stage_hs.sv
// Scoreboard bench for mem_stage_hs: a reference model queues expected requests and results,
// a memory responder acks with a programmed delay, and a monitor compares what the stage emits.
module tb_mem_stage_hs;

   localparam int TMO = 4;

   typedef struct {
      logic [4:0]  wd;
      logic        wreg;
      logic [31:0] wdata;
      logic        mis;
      logic        tmo;
      logic        chkData;
   } expT;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
   } reqT;

   typedef struct {
      int          delay;
      logic [31:0] data;
   } respT;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  wd_i;
   logic        wreg_i;
   logic [31:0] wdata_i;
   logic [3:0]  memop_i;
   logic [31:0] addr_i;
   logic [31:0] sdata_i;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic        out_valid;
   logic [4:0]  wd_o;
   logic        wreg_o;
   logic [31:0] wdata_o;
   logic        stall_req;
   logic        misalign_o;
   logic        timeout_o;

   expT  outQ[$];
   reqT  reqQ[$];
   respT respQ[$];

   int assertCount = 0;
   int failCount   = 0;
   int stallCycles = 0;
   int reqHighCycles = 0;
   bit strayAck = 0;

   mem_stage_hs #(
      .ADDR_W(32),
      .REG_ADDR_W(5),
      .ACK_TIMEOUT(TMO)
   ) dut (
      .clk(clk),
      .rst(rst),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .wd_i(wd_i),
      .wreg_i(wreg_i),
      .wdata_i(wdata_i),
      .memop_i(memop_i),
      .addr_i(addr_i),
      .sdata_i(sdata_i),
      .mem_req(mem_req),
      .mem_we(mem_we),
      .mem_addr(mem_addr),
      .mem_be(mem_be),
      .mem_wdata(mem_wdata),
      .mem_ack(mem_ack),
      .mem_rdata(mem_rdata),
      .out_valid(out_valid),
      .wd_o(wd_o),
      .wreg_o(wreg_o),
      .wdata_o(wdata_o),
      .stall_req(stall_req),
      .misalign_o(misalign_o),
      .timeout_o(timeout_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
      end
   endtask

   // Reference model: computes the request and result this instruction must produce, then drives it
   // and holds in_valid until the stage reports ready.
   task automatic applyStimulus(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                                input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                                input int delay, input logic [31:0] rdata);
      logic [1:0]  a;
      logic        isLd, isSt, mis, accepted;
      logic [31:0] sh;
      expT         e;
      reqT         r;
      respT        p;
      a    = addr[1:0];
      isLd = (op >= 4'd1) && (op <= 4'd5);
      isSt = (op >= 4'd6) && (op <= 4'd8);
      mis  = (((op == 4'd3) || (op == 4'd4) || (op == 4'd7)) && a[0]) ||
             (((op == 4'd5) || (op == 4'd8)) && (a != 2'd0));
      e = '{wd: wd, wreg: wreg, wdata: wdata, mis: 1'b0, tmo: 1'b0, chkData: 1'b1};
      if (mis) begin
         e = '{wd: wd, wreg: 1'b0, wdata: addr, mis: 1'b1, tmo: 1'b0, chkData: 1'b1};
      end else if (isLd || isSt) begin
         r.we    = isSt;
         r.addr  = {addr[31:2], 2'b00};
         r.be    = 4'b1111;
         r.wdata = sdata;
         if (op == 4'd6) begin
            r.be    = 4'b0001 << a;
            r.wdata = {4{sdata[7:0]}};
         end else if (op == 4'd7) begin
            r.be    = (a == 2'd2) ? 4'b1100 : 4'b0011;
            r.wdata = {2{sdata[15:0]}};
         end
         reqQ.push_back(r);
         p.delay = delay;
         p.data  = rdata;
         respQ.push_back(p);
         sh = rdata >> (8 * a);
         if (delay < 0 || delay >= TMO) begin
            e = '{wd: wd, wreg: 1'b0, wdata: 32'd0, mis: 1'b0, tmo: 1'b1, chkData: 1'b0};
         end else if (isSt) begin
            e = '{wd: wd, wreg: 1'b0, wdata: 32'd0, mis: 1'b0, tmo: 1'b0, chkData: 1'b1};
         end else begin
            case (op)
               4'd1:    e.wdata = {{24{sh[7]}}, sh[7:0]};
               4'd2:    e.wdata = {24'd0, sh[7:0]};
               4'd3:    e.wdata = {{16{sh[15]}}, sh[15:0]};
               4'd4:    e.wdata = {16'd0, sh[15:0]};
               default: e.wdata = rdata;
            endcase
         end
      end
      outQ.push_back(e);

      @(negedge clk);
      in_valid = 1'b1;
      memop_i  = op;
      addr_i   = addr;
      sdata_i  = sdata;
      wd_i     = wd;
      wreg_i   = wreg;
      wdata_i  = wdata;
      accepted = 1'b0;
      for (int n = 0; n < 100 && !accepted; n++) begin
         accepted = in_ready;
         @(negedge clk);
      end
      in_valid = 1'b0;
      if (!accepted) checkOutput("acceptTimeout", 32'd0, 32'd1);
   endtask

   task automatic waitDrain();
      int n;
      n = 0;
      while ((outQ.size() > 0 || stall_req) && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) checkOutput("drainTimeout", 32'd0, 32'd1);
   endtask

   // Memory model: acks the n-th request cycle as programmed, or pulses a stray ack while idle.
   initial begin : responder
      int   reqCycles;
      respT cur;
      reqCycles = 0;
      cur.delay = -1;
      cur.data  = 32'd0;
      mem_ack   = 1'b0;
      mem_rdata = 32'd0;
      forever begin
         @(negedge clk);
         mem_ack = 1'b0;
         if (rst) begin
            reqCycles = 0;
         end else if (mem_req) begin
            if (reqCycles == 0) begin
               if (respQ.size() > 0) cur = respQ.pop_front();
               else cur.delay = -1;
            end
            if (reqCycles == cur.delay) begin
               mem_ack   = 1'b1;
               mem_rdata = cur.data;
            end
            reqCycles++;
         end else begin
            reqCycles = 0;
            if (strayAck) begin
               mem_ack   = 1'b1;
               mem_rdata = 32'hDEAD_0000;
               strayAck  = 0;
            end
         end
      end
   end

   // Monitor: checks each new request and each result against the scoreboard queues.
   initial begin : monitor
      bit  prevReq;
      reqT r;
      expT e;
      prevReq = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prevReq = 0;
         end else begin
            if (stall_req) stallCycles++;
            if (mem_req) reqHighCycles++;
            if (mem_req && !prevReq) begin
               if (reqQ.size() == 0) begin
                  checkOutput("unexpectedReq", 32'd1, 32'd0);
               end else begin
                  r = reqQ.pop_front();
                  checkOutput("reqWe", {31'd0, mem_we}, {31'd0, r.we});
                  checkOutput("reqAddr", mem_addr, r.addr);
                  checkOutput("reqBe", {28'd0, mem_be}, {28'd0, r.be});
                  checkOutput("reqWdata", mem_wdata, r.wdata);
               end
            end
            prevReq = mem_req;
            if (out_valid) begin
               if (outQ.size() == 0) begin
                  checkOutput("unexpectedValid", 32'd1, 32'd0);
               end else begin
                  e = outQ.pop_front();
                  checkOutput("resWreg", {31'd0, wreg_o}, {31'd0, e.wreg});
                  checkOutput("resMisalign", {31'd0, misalign_o}, {31'd0, e.mis});
                  checkOutput("resTimeout", {31'd0, timeout_o}, {31'd0, e.tmo});
                  if (e.chkData) begin
                     checkOutput("resWd", {27'd0, wd_o}, {27'd0, e.wd});
                     checkOutput("resWdata", wdata_o, e.wdata);
                  end
               end
            end else if (misalign_o || timeout_o) begin
               checkOutput("strayPulse", {30'd0, misalign_o, timeout_o}, 32'd0);
            end
         end
      end
   end

   initial begin
      rst      = 1'b1;
      in_valid = 1'b0;
      memop_i  = 4'd0;
      addr_i   = 32'd0;
      sdata_i  = 32'd0;
      wd_i     = 5'd0;
      wreg_i   = 1'b0;
      wdata_i  = 32'd0;
      #3;
      checkOutput("rstOutValid", {31'd0, out_valid}, 32'd0);
      checkOutput("rstMemReq", {31'd0, mem_req}, 32'd0);
      checkOutput("rstWdata", wdata_o, 32'd0);
      checkOutput("rstWd", {27'd0, wd_o}, 32'd0);
      checkOutput("rstBe", {28'd0, mem_be}, 32'd0);
      checkOutput("rstAddr", mem_addr, 32'd0);
      checkOutput("rstInReady", {31'd0, in_ready}, 32'd1);
      checkOutput("rstStall", {31'd0, stall_req}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      $display("[TB] passthrough");
      applyStimulus(4'd0, 32'h0, 32'h0, 5'd5, 1'b1, 32'h0000_1234, 0, 32'h0);
      checkOutput("ptLatency", {31'd0, out_valid}, 32'd1);
      checkOutput("ptNoReq", {31'd0, mem_req}, 32'd0);
      waitDrain();

      $display("[TB] loads");
      stallCycles = 0;
      applyStimulus(4'd1, 32'h103, 32'h0, 5'd7, 1'b1, 32'h0, 3, 32'h80FF_0000);
      waitDrain();
      checkOutput("lbStallCycles", 32'(stallCycles), 32'd4);
      applyStimulus(4'd2, 32'h103, 32'h0, 5'd8, 1'b1, 32'h0, 3, 32'h80FF_0000);
      applyStimulus(4'd3, 32'h102, 32'h0, 5'd9, 1'b1, 32'h0, 1, 32'h8001_7F00);
      applyStimulus(4'd4, 32'h100, 32'h0, 5'd10, 1'b1, 32'h0, 2, 32'h1234_F00D);
      applyStimulus(4'd5, 32'h40, 32'h0, 5'd11, 1'b1, 32'h0, 0, 32'hCAFE_BABE);
      applyStimulus(4'd1, 32'h101, 32'h0, 5'd12, 1'b0, 32'h0, 1, 32'h0000_7F00);
      waitDrain();

      $display("[TB] stores");
      applyStimulus(4'd7, 32'h22, 32'hDEAD_BEEF, 5'd3, 1'b1, 32'h0, 0, 32'h0);
      applyStimulus(4'd6, 32'h31, 32'h1234_5678, 5'd4, 1'b1, 32'h0, 2, 32'h0);
      applyStimulus(4'd8, 32'h44, 32'hA5A5_0F0F, 5'd6, 1'b1, 32'h0, 1, 32'h0);
      applyStimulus(4'd7, 32'h50, 32'h0000_C3C3, 5'd2, 1'b1, 32'h0, 0, 32'h0);
      waitDrain();

      $display("[TB] misaligned and unused opcodes");
      applyStimulus(4'd5, 32'h2, 32'h0, 5'd13, 1'b1, 32'h0, 0, 32'h0);
      checkOutput("misPulse", {31'd0, misalign_o}, 32'd1);
      checkOutput("misNoReq", {31'd0, mem_req}, 32'd0);
      applyStimulus(4'd3, 32'h5, 32'h0, 5'd14, 1'b1, 32'h0, 0, 32'h0);
      applyStimulus(4'd7, 32'h23, 32'h0, 5'd15, 1'b1, 32'h0, 0, 32'h0);
      applyStimulus(4'd12, 32'h3, 32'h0, 5'd16, 1'b1, 32'h0000_BEEF, 0, 32'h0);
      waitDrain();

      $display("[TB] back-to-back with stall");
      applyStimulus(4'd5, 32'h60, 32'h0, 5'd17, 1'b1, 32'h0, 2, 32'h0BAD_F00D);
      checkOutput("waitNotReady", {31'd0, in_ready}, 32'd0);
      applyStimulus(4'd0, 32'h0, 32'h0, 5'd18, 1'b1, 32'h0000_5555, 0, 32'h0);
      waitDrain();

      $display("[TB] stray ack while idle");
      strayAck = 1;
      repeat (4) @(negedge clk);
      checkOutput("strayNoValid", {31'd0, out_valid}, 32'd0);

      $display("[TB] ack timeout");
      reqHighCycles = 0;
      applyStimulus(4'd5, 32'h80, 32'h0, 5'd19, 1'b1, 32'h0, -1, 32'h0);
      waitDrain();
      checkOutput("tmoReqCycles", 32'(reqHighCycles), 32'(TMO));
      checkOutput("tmoInReady", {31'd0, in_ready}, 32'd1);

      $display("[TB] reset during wait");
      applyStimulus(4'd5, 32'h90, 32'h0, 5'd20, 1'b1, 32'h0, -1, 32'h0);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      checkOutput("rstWaitReq", {31'd0, mem_req}, 32'd0);
      checkOutput("rstWaitStall", {31'd0, stall_req}, 32'd0);
      checkOutput("rstWaitValid", {31'd0, out_valid}, 32'd0);
      outQ.delete();
      reqQ.delete();
      respQ.delete();
      @(negedge clk);
      rst = 1'b0;
      applyStimulus(4'd0, 32'h0, 32'h0, 5'd21, 1'b1, 32'h0000_00AB, 0, 32'h0);
      checkOutput("postRstValid", {31'd0, out_valid}, 32'd1);
      waitDrain();

      checkOutput("reqQEmpty", 32'(reqQ.size()), 32'd0);
      checkOutput("outQEmpty", 32'(outQ.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule

// File: doc/mem_stage_hs.md
Name: mem_stage_hs

Overview:
Next-generation MEM stage of the flowCPU MIPS32 pipeline, between EX and WB. Passes write-back information (destination register, write enable, data) through. Adds real load/store execution against a data memory with a req/ack handshake of variable latency, byte-lane alignment, sign/zero extension, misalignment detection and an optional ack timeout. Registered outputs; the stage stalls the upstream pipeline while a memory access is outstanding.

Parameters:
ADDR_W, 32, data-memory byte-address width
REG_ADDR_W, 5, register-file address width
ACK_TIMEOUT, 0, max cycles waiting for mem_ack; 0 = timeout disabled

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  EX result valid this cycle
in_ready  out  1  stage can accept; combinational, equals (state==IDLE)
wd_i  in  REG_ADDR_W  destination register
wreg_i  in  1  register write enable
wdata_i  in  32  ALU result
memop_i  in  4  0 NONE, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW; 9-15 treated as NONE
addr_i  in  ADDR_W  effective byte address
sdata_i  in  32  store data (rt)
mem_req  out  1  memory request, registered
mem_we  out  1  1 = store
mem_addr  out  ADDR_W  word address {addr_i[ADDR_W-1:2],2'b00}
mem_be  out  4  byte enables
mem_wdata  out  32  lane-replicated store data
mem_ack  in  1  memory completes request (1-cycle pulse)
mem_rdata  in  32  read data, valid with mem_ack
out_valid  out  1  result to WB valid (1-cycle pulse per instruction)
wd_o  out  REG_ADDR_W  destination register to WB
wreg_o  out  1  write enable to WB
wdata_o  out  32  write-back data
stall_req  out  1  pipeline stall request, high whenever state!=IDLE
misalign_o  out  1  address-error pulse, with out_valid
timeout_o  out  1  ack-timeout pulse, with out_valid

Behaviour:
- Reset (async): state=IDLE; all registered outputs 0 (wd_o=0, wreg_o=0, wdata_o=0, mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, out_valid=0, misalign_o=0, timeout_o=0). Assertion mid-WAIT drops mem_req immediately; the pending instruction is lost.
- FSM states IDLE, WAIT.
- IDLE, in_valid=0: out_valid=0 next cycle; other outputs hold.
- IDLE, in_valid=1, memop NONE: next edge wd_o/wreg_o/wdata_o <= inputs, out_valid=1; latency 1; stay IDLE.
- Misalignment: LH/LHU/SH with addr_i[0]=1; LW/SW with addr_i[1:0]!=0. Next edge out_valid=1, misalign_o=1, wreg_o=0, wd_o=wd_i, wdata_o=addr_i zero-extended/truncated to 32; no mem_req; stay IDLE.
- IDLE, aligned load/store: next edge mem_req=1, mem_we, mem_addr, mem_be, mem_wdata set, latched wd/wreg/memop/addr[1:0]; go to WAIT; out_valid=0.
- Byte lanes (little-endian, a=addr[1:0]): SB be=1<<a, wdata={4{sdata[7:0]}}; SH be=a[1]?1100:0011, wdata={2{sdata[15:0]}}; SW be=1111, wdata=sdata. Loads: be=1111, mem_we=0.
- WAIT: mem_req and request fields held stable until mem_ack. On mem_ack: mem_req<=0, out_valid<=1, go to IDLE. Loads: wdata_o = selected byte/halfword of mem_rdata by latched a, sign-extended (LB/LH) or zero-extended (LBU/LHU); LW full word; wreg_o=latched wreg. Stores: wreg_o=0, wdata_o=0.
- Minimum load/store latency: request issued 1 cycle after acceptance; result out_valid on the edge after mem_ack. The ack may arrive the first cycle mem_req is high.
- Timeout (ACK_TIMEOUT>0): counter cleared on entering WAIT, increments each WAIT cycle without ack. Reaching ACK_TIMEOUT: mem_req<=0, out_valid=1, timeout_o=1, wreg_o=0, go to IDLE. Ack and timeout in same cycle: ack wins.
- mem_ack while IDLE: ignored.
- in_valid while WAIT: not accepted (in_ready=0); upstream must hold its data.
- misalign_o/timeout_o are 0 on all cycles other than their pulse.

Test Plan:
- Passthrough: memop=0, wd_i=5, wreg_i=1, wdata_i=0x1234 -> next cycle out_valid=1, wd_o=5, wreg_o=1, wdata_o=0x1234; mem_req stays 0.
- LB sign extension: addr=0x103, ack after 3 cycles with rdata=0x80FF_0000 -> mem_addr=0x100, be=1111, stall_req high 4 cycles, wdata_o=0xFFFF_FF80; same with LBU -> 0x0000_0080.
- SH: addr=0x22, sdata=0xDEAD_BEEF, immediate ack -> mem_we=1, be=1100, mem_wdata=0xBEEF_BEEF, out_valid with wreg_o=0.
- Misaligned LW addr=0x2 -> no mem_req, out_valid=1, misalign_o=1, wreg_o=0, wdata_o=0x2.
- Timeout: ACK_TIMEOUT=4, LW, no ack -> mem_req high exactly 4 cycles, then out_valid=1, timeout_o=1, wreg_o=0, in_ready=1.
- Reset mid-WAIT: assert rst between edges during an LW -> mem_req, stall_req and out_valid drop to 0 immediately; after release, a passthrough instruction completes normally.
